// File: rtl/morse_pkg.sv
// Shared types and timing constants for the Morse decoder.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE
  } state_t;

  localparam int unsigned DOT_DASH_UNITS   = 2;
  localparam int unsigned LETTER_GAP_UNITS = 2;
  localparam int unsigned WORD_GAP_UNITS   = 5;
  localparam int unsigned MAX_ELEMS        = 6;

  // A completed symbol as handed from the keying FSM to the output register.
  typedef struct packed {
    logic [2:0] len;
    logic [5:0] bits;
    logic       word;
    logic       err;
  } sym_t;

endpackage

// File: rtl/morse_ascii_lut.sv
// Combinational Morse pattern to ASCII lookup (bit0 = first element, 1 = dash).
// Length 0 is the word-gap symbol and maps to a space; unknown patterns map to '?'.
module morse_ascii_lut (
  input  logic [2:0] sym_len,
  input  logic [5:0] sym_bits,
  output logic [7:0] ascii
);

  // Pattern decode keyed on length and element bits together.
  always_comb begin
    ascii = 8'h3F;
    case ({sym_len, sym_bits})
      {3'd0, 6'b000000}: ascii = 8'h20;
      {3'd1, 6'b000000}: ascii = "E";
      {3'd1, 6'b000001}: ascii = "T";
      {3'd2, 6'b000000}: ascii = "I";
      {3'd2, 6'b000010}: ascii = "A";
      {3'd2, 6'b000001}: ascii = "N";
      {3'd2, 6'b000011}: ascii = "M";
      {3'd3, 6'b000000}: ascii = "S";
      {3'd3, 6'b000100}: ascii = "U";
      {3'd3, 6'b000010}: ascii = "R";
      {3'd3, 6'b000110}: ascii = "W";
      {3'd3, 6'b000001}: ascii = "D";
      {3'd3, 6'b000101}: ascii = "K";
      {3'd3, 6'b000011}: ascii = "G";
      {3'd3, 6'b000111}: ascii = "O";
      {3'd4, 6'b000000}: ascii = "H";
      {3'd4, 6'b001000}: ascii = "V";
      {3'd4, 6'b000100}: ascii = "F";
      {3'd4, 6'b000010}: ascii = "L";
      {3'd4, 6'b000110}: ascii = "P";
      {3'd4, 6'b001110}: ascii = "J";
      {3'd4, 6'b000001}: ascii = "B";
      {3'd4, 6'b001001}: ascii = "X";
      {3'd4, 6'b000101}: ascii = "C";
      {3'd4, 6'b001101}: ascii = "Y";
      {3'd4, 6'b000011}: ascii = "Z";
      {3'd4, 6'b001011}: ascii = "Q";
      {3'd5, 6'b011111}: ascii = "0";
      {3'd5, 6'b011110}: ascii = "1";
      {3'd5, 6'b011100}: ascii = "2";
      {3'd5, 6'b011000}: ascii = "3";
      {3'd5, 6'b010000}: ascii = "4";
      {3'd5, 6'b000000}: ascii = "5";
      {3'd5, 6'b000001}: ascii = "6";
      {3'd5, 6'b000011}: ascii = "7";
      {3'd5, 6'b000111}: ascii = "8";
      {3'd5, 6'b001111}: ascii = "9";
      default:           ascii = 8'h3F;
    endcase
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse keyed-line decoder: synchronizes the line, times marks and spaces with
// a single saturating run counter, assembles letters and word gaps into a
// one-deep valid/ready output register.
// Optional feature: define MORSE_ASCII_EN to build the ASCII lookup; otherwise
// sym_ascii is tied to 8'h00.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_LOG2 = 19
) (
  input  logic       morse_clk,
  input  logic       sys_rst,
  input  logic       data,
  output logic       sym_valid,
  input  logic       sym_ready,
  output logic [2:0] sym_len,
  output logic [5:0] sym_bits,
  output logic       sym_word,
  output logic       sym_err,
  output logic [7:0] sym_ascii,
  output logic       overrun
);

  localparam int unsigned CW = UNIT_LOG2 + 3;
  localparam logic [CW-1:0] DOT_LIMIT  = CW'(DOT_DASH_UNITS) << UNIT_LOG2;
  localparam logic [CW-1:0] LETTER_CNT = CW'(LETTER_GAP_UNITS) << UNIT_LOG2;
  localparam logic [CW-1:0] WORD_CNT   = CW'(WORD_GAP_UNITS) << UNIT_LOG2;

  logic          data_s1, data_s2, data_prev;
  logic          rise, fall, level_change;
  logic [CW-1:0] run_cnt;
  state_t        state;
  logic [2:0]    pat_len;
  logic [5:0]    pat_bits;
  logic          pat_err;
  logic          done;
  sym_t          done_sym;
  logic          accept, load;

  assign rise         = data_s2 & ~data_prev;
  assign fall         = ~data_s2 & data_prev;
  assign level_change = data_s2 ^ data_prev;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge morse_clk) begin
    if (sys_rst) begin
      data_s1   <= 1'b0;
      data_s2   <= 1'b0;
      data_prev <= 1'b0;
    end else begin
      data_s1   <= data;
      data_s2   <= data_s1;
      data_prev <= data_s2;
    end
  end

  // Run-length counter: held at zero while idle, cleared on each level change, saturating.
  always_ff @(posedge morse_clk) begin
    if (sys_rst || state == IDLE || level_change) begin
      run_cnt <= '0;
    end else if (run_cnt != '1) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // Keying FSM: classifies marks, accumulates the pattern, emits letters and word gaps.
  always_ff @(posedge morse_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      pat_len  <= '0;
      pat_bits <= '0;
      pat_err  <= 1'b0;
      done     <= 1'b0;
      done_sym <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) state <= MARK;
        end
        MARK: begin
          if (fall) begin
            state <= SPACE;
            if (pat_len < 3'(MAX_ELEMS)) begin
              pat_bits <= pat_bits | (6'(run_cnt >= DOT_LIMIT) << pat_len);
              pat_len  <= pat_len + 3'd1;
            end else begin
              pat_err <= 1'b1;
            end
          end
        end
        SPACE: begin
          // Letter completion is evaluated even on a rising edge so a gap of
          // exactly two units still closes the letter before the next mark.
          if (run_cnt == LETTER_CNT && pat_len != '0) begin
            done     <= 1'b1;
            done_sym <= '{len: pat_len, bits: pat_bits, word: 1'b0, err: pat_err};
            pat_len  <= '0;
            pat_bits <= '0;
            pat_err  <= 1'b0;
          end
          if (rise) begin
            state <= MARK;
          end else if (run_cnt == WORD_CNT) begin
            done     <= 1'b1;
            done_sym <= '{len: 3'd0, bits: 6'd0, word: 1'b1, err: 1'b0};
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign accept = sym_valid & sym_ready;
  assign load   = done & (~sym_valid | accept);

  // One-deep output register with valid/ready handshake and overrun flag.
  always_ff @(posedge morse_clk) begin
    if (sys_rst) begin
      sym_valid <= 1'b0;
      sym_len   <= '0;
      sym_bits  <= '0;
      sym_word  <= 1'b0;
      sym_err   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= done & ~load;
      if (load) begin
        sym_valid <= 1'b1;
        sym_len   <= done_sym.len;
        sym_bits  <= done_sym.bits;
        sym_word  <= done_sym.word;
        sym_err   <= done_sym.err;
      end else if (accept) begin
        sym_valid <= 1'b0;
      end
    end
  end

`ifdef MORSE_ASCII_EN
  logic [7:0] lut_ascii;

  morse_ascii_lut u_ascii_lut (
    .sym_len  (done_sym.len),
    .sym_bits (done_sym.bits),
    .ascii    (lut_ascii)
  );

  // ASCII register loads alongside the symbol; overflowed letters read as '?'.
  always_ff @(posedge morse_clk) begin
    if (sys_rst) begin
      sym_ascii <= '0;
    end else if (load) begin
      sym_ascii <= done_sym.err ? 8'h3F : lut_ascii;
    end
  end
`else
  assign sym_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_morse_decoder.sv
// Randomized scoreboard bench for morse_decoder at 4 cycles per unit.
module tb_morse_decoder;

  localparam int unsigned UL   = 2;
  localparam int          UNIT = 1 << UL;

  logic       morse_clk = 1'b0;
  logic       sys_rst   = 1'b1;
  logic       data      = 1'b0;
  logic       sym_ready = 1'b1;
  logic       sym_valid, sym_word, sym_err, overrun;
  logic [2:0] sym_len;
  logic [5:0] sym_bits;
  logic [7:0] sym_ascii;

  morse_decoder #(.UNIT_LOG2(UL)) dut (
    .morse_clk (morse_clk),
    .sys_rst   (sys_rst),
    .data      (data),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .sym_len   (sym_len),
    .sym_bits  (sym_bits),
    .sym_word  (sym_word),
    .sym_err   (sym_err),
    .sym_ascii (sym_ascii),
    .overrun   (overrun)
  );

  always #5 morse_clk = ~morse_clk;

  typedef struct {
    int len;
    int bits;
    int word;
    int err;
    int ascii;
  } exp_t;

  exp_t  sbq[$];
  int    errors  = 0;
  int    checks  = 0;
  int    ovr_cnt = 0;

  string codes[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                       ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                       "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                       "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                       "--...", "---..", "----."};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic exp_t model_letter(input string s);
    exp_t e;
    int   n = s.len();
    e.err  = (n > 6) ? 1 : 0;
    e.len  = (n > 6) ? 6 : n;
    e.word = 0;
    e.bits = 0;
    for (int i = 0; i < e.len; i++)
      if (s[i] == 8'h2D) e.bits += (1 << i);
    e.ascii = 8'h3F;
    if (e.err == 0)
      for (int k = 0; k < 36; k++)
        if (codes[k] == s) e.ascii = (k < 26) ? (65 + k) : (22 + k);
`ifndef MORSE_ASCII_EN
    e.ascii = 0;
`endif
    return e;
  endfunction

  function automatic exp_t model_word();
    exp_t e;
    e.len = 0; e.bits = 0; e.word = 1; e.err = 0;
`ifdef MORSE_ASCII_EN
    e.ascii = 8'h20;
`else
    e.ascii = 0;
`endif
    return e;
  endfunction

  // Monitor: pops the scoreboard on every handshake and counts overrun pulses.
  always @(negedge morse_clk) begin
    if (!sys_rst) begin
      if (overrun) ovr_cnt++;
      if (sym_valid && sym_ready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_symbol: actual len=%0d bits=%0d word=%0d required none",
                   sym_len, sym_bits, sym_word);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sym_len",   int'(sym_len),   e.len);
          check("sym_bits",  int'(sym_bits),  e.bits);
          check("sym_word",  int'(sym_word),  e.word);
          check("sym_err",   int'(sym_err),   e.err);
          check("sym_ascii", int'(sym_ascii), e.ascii);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge morse_clk);
    #1;
  endtask

  task automatic level(input logic v, input int units);
    data = v;
    wait_cyc(units * UNIT);
  endtask

  // Keys the elements of a letter with one-unit intra-letter gaps; caller adds the trailing gap.
  task automatic key_letter(input string s);
    for (int i = 0; i < s.len(); i++) begin
      level(1'b1, (s[i] == 8'h2D) ? 3 : 1);
      if (i < s.len() - 1) level(1'b0, 1);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && sbq.size() != 0; i++) wait_cyc(1);
    check(name, sbq.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, int'(sym_valid), 0);
    check({tag, "_len"},   int'(sym_len),   0);
    check({tag, "_bits"},  int'(sym_bits),  0);
    check({tag, "_word"},  int'(sym_word),  0);
    check({tag, "_err"},   int'(sym_err),   0);
    check({tag, "_ascii"}, int'(sym_ascii), 0);
    check({tag, "_ovr"},   int'(overrun),   0);
  endtask

  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int ovr0;

    sys_rst = 1'b1;
    wait_cyc(3);
    check_idle_outputs("reset");
    sys_rst = 1'b0;
    wait_cyc(2);

    // Letter F followed by a word gap
    sbq.push_back(model_letter("..-."));
    sbq.push_back(model_word());
    key_letter("..-.");
    level(1'b0, 7);
    drain("drain_f");

    // Seven dots overflow the pattern
    sbq.push_back(model_letter("......."));
    sbq.push_back(model_word());
    key_letter(".......");
    level(1'b0, 7);
    drain("drain_err");

    // Ten-unit mark saturates the counter and still reads as one dash
    sbq.push_back(model_letter("-"));
    sbq.push_back(model_word());
    level(1'b1, 10);
    level(1'b0, 7);
    drain("drain_sat");

    // Backpressure: E held, T dropped with a single overrun pulse
    sym_ready = 1'b0;
    ovr0 = ovr_cnt;
    sbq.push_back(model_letter("."));
    key_letter(".");
    level(1'b0, 4);
    check("hold_e_valid", int'(sym_valid), 1);
    check("hold_e_len",   int'(sym_len),   1);
    check("hold_e_bits",  int'(sym_bits),  0);
    key_letter("-");
    level(1'b0, 4);
    check("hold_after_t_valid", int'(sym_valid), 1);
    check("hold_after_t_len",   int'(sym_len),   1);
    check("hold_after_t_bits",  int'(sym_bits),  0);
    check("overrun_pulses",     ovr_cnt - ovr0,  1);
    sbq.push_back(model_word());
    sym_ready = 1'b1;
    level(1'b0, 3);
    drain("drain_ovr");

    // Reset in the middle of a letter discards it
    key_letter("..");
    wait_cyc(2);
    sys_rst = 1'b1;
    wait_cyc(3);
    check_idle_outputs("midrst");
    sys_rst = 1'b0;
    level(1'b0, 2);
    sbq.push_back(model_letter("-"));
    sbq.push_back(model_word());
    key_letter("-");
    level(1'b0, 7);
    drain("drain_rst");

    // Random words from the alphabet plus occasional arbitrary patterns
    for (int w = 0; w < 8; w++) begin
      int nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) begin
        string s = "";
        if ($urandom_range(0, 9) == 0) begin
          int n = $urandom_range(1, 7);
          for (int k = 0; k < n; k++) s = {s, ($urandom_range(0, 1) != 0) ? "-" : "."};
        end else begin
          s = codes[$urandom_range(0, 35)];
        end
        sbq.push_back(model_letter(s));
        key_letter(s);
        if (l < nl - 1) level(1'b0, 3);
      end
      sbq.push_back(model_word());
      level(1'b0, 7);
    end
    drain("drain_rand");

    check("overrun_total", ovr_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
